axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master_if.sv | 61 ++++++
 rtl/axi_burst_master.sv | 176 +++++++++++++++++
 tb/tb_axi_burst_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_master_if.sv
// AXI-style address/data/response channel bundle between the burst master and its slave.
// Field widths follow the master's ADDR_W and DATA_W.
interface axi_burst_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic [DATA_W-1:0] rdata;
    logic              rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;

    logic              bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wlast,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wlast,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-command INCR burst master: one read or write burst per accepted command,
// with a per-wait timeout and a registered done/err status pulse.
module axi_burst_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              res,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    axi_burst_master_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        len_reg;
    logic [2:0]        size_reg;
    logic [3:0]        beat_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic              err_acc_reg;
    logic              armed_reg;
    logic              done_reg;
    logic              err_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;

    logic accept, ar_hs, aw_hs, r_hs, w_hs, b_hs, any_hs;
    logic busy, last_beat, timeout, r_end, finish, err_val;
    logic arvalid_c, awvalid_c, rready_c, wvalid_c, bready_c, wlast_c, cmd_ready_c;

    assign accept    = cmd_valid && cmd_ready_c;
    assign ar_hs     = (state_reg == AR) && bus.arready;
    assign aw_hs     = (state_reg == AW) && bus.awready;
    assign r_hs      = (state_reg == R)  && bus.rvalid;
    assign w_hs      = (state_reg == W)  && bus.wready;
    assign b_hs      = (state_reg == B)  && bus.bvalid;
    assign any_hs    = ar_hs || aw_hs || r_hs || w_hs || b_hs;
    assign busy      = (state_reg != IDLE);
    assign last_beat = (beat_reg == len_reg);
    assign timeout   = busy && !any_hs && (wait_reg == WAIT_LAST);
    // A read ends on the expected last beat or on an early rlast, whichever comes first.
    assign r_end     = r_hs && (last_beat || bus.rlast);
    assign finish    = r_end || b_hs || timeout;
    assign err_val   = timeout ||
                       (b_hs ? bus.bresp
                             : (err_acc_reg || bus.rresp || !(last_beat && bus.rlast)));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = cmd_write ? AW : AR;
            AR:   if (ar_hs) state_next = R;
            R:    if (r_end) state_next = IDLE;
            AW:   if (aw_hs) state_next = W;
            W:    if (w_hs && last_beat) state_next = B;
            B:    if (b_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next = IDLE;
        end
    end

    // cmd_ready waits out the done cycle so status and the next accept never overlap.
    always_comb begin
        cmd_ready_c = 1'b0;
        arvalid_c   = 1'b0;
        awvalid_c   = 1'b0;
        rready_c    = 1'b0;
        wvalid_c    = 1'b0;
        wlast_c     = 1'b0;
        bready_c    = 1'b0;
        case (state_reg)
            IDLE: cmd_ready_c = armed_reg && !done_reg;
            AR:   arvalid_c   = 1'b1;
            R:    rready_c    = 1'b1;
            AW:   awvalid_c   = 1'b1;
            W: begin
                wvalid_c = 1'b1;
                wlast_c  = last_beat;
            end
            B:    bready_c    = 1'b1;
            default: cmd_ready_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            addr_reg     <= '0;
            len_reg      <= '0;
            size_reg     <= '0;
            beat_reg     <= '0;
            wait_reg     <= '0;
            err_acc_reg  <= 1'b0;
            armed_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            armed_reg    <= 1'b1;
            done_reg     <= finish;
            err_reg      <= finish && err_val;
            rd_valid_reg <= r_hs;
            if (r_hs) begin
                rd_data_reg <= bus.rdata;
            end
            if (accept) begin
                addr_reg    <= cmd_addr;
                len_reg     <= cmd_len;
                size_reg    <= cmd_size;
                beat_reg    <= '0;
                wait_reg    <= '0;
                err_acc_reg <= 1'b0;
            end else begin
                if (any_hs || !busy) begin
                    wait_reg <= '0;
                end else begin
                    wait_reg <= wait_reg + WAIT_W'(1);
                end
                if (r_hs || w_hs) begin
                    beat_reg <= beat_reg + 4'd1;
                end
                if (r_hs) begin
                    err_acc_reg <= err_acc_reg || bus.rresp;
                end
            end
        end
    end

    assign cmd_ready   = cmd_ready_c;
    assign wr_req      = w_hs;
    assign rd_data     = rd_data_reg;
    assign rd_valid    = rd_valid_reg;
    assign done        = done_reg;
    assign err         = err_reg;

    assign bus.arvalid = arvalid_c;
    assign bus.araddr  = addr_reg;
    assign bus.arlen   = len_reg;
    assign bus.arsize  = size_reg;
    assign bus.arburst = 2'b01;
    assign bus.rready  = rready_c;
    assign bus.awvalid = awvalid_c;
    assign bus.awaddr  = addr_reg;
    assign bus.awlen   = len_reg;
    assign bus.awsize  = size_reg;
    assign bus.awburst = 2'b01;
    assign bus.wvalid  = wvalid_c;
    assign bus.wdata   = wr_data;
    assign bus.wlast   = wlast_c;
    assign bus.bready  = bready_c;
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: read/write bursts, early rlast, single-beat
// bursts, address timeout and reset in the middle of a write burst.
module tb_axi_burst_master;
    logic        clk = 1'b0;
    logic        res;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [15:0] wr_data;
    logic        wr_req;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;
    int arv_cycles;

    logic [15:0] rd_tab [4] = '{16'h1234, 16'hbeef, 16'h0f0f, 16'ha5a5};
    logic [15:0] wd_tab [4] = '{16'hff11, 16'h11aa, 16'h0011, 16'h1110};

    axi_burst_master_if #(.ADDR_W(5), .DATA_W(16)) bus ();

    axi_burst_master #(.ADDR_W(5), .DATA_W(16), .TIMEOUT(64)) dut (
        .clk       (clk),
        .res       (res),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one accept edge, then withdraw it.
    task automatic start_cmd(input logic wr, input logic [4:0] addr,
                             input logic [3:0] len, input logic [2:0] size);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        #1;
        chk("cmd_ready_at_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        res = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        wr_data = '0;
        bus.arready = 0; bus.awready = 0; bus.wready = 0;
        bus.rdata = '0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
        bus.bresp = 0; bus.bvalid = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_rd_valid", rd_valid, 0);
        #1;
        res = 1'b0;
        #1;
        chk("rel_cmd_ready_before_edge", cmd_ready, 0);
        tick();
        chk("rel_cmd_ready_after_edge", cmd_ready, 1);

        // Read burst, 4 beats, rlast on the 4th
        start_cmd(1'b0, 5'h00, 4'd3, 3'd0);
        #1;
        chk("rd_arvalid", bus.arvalid, 1);
        chk("rd_araddr", bus.araddr, 5'h00);
        chk("rd_arlen", bus.arlen, 4'd3);
        chk("rd_arsize", bus.arsize, 3'd0);
        chk("rd_arburst", bus.arburst, 2'b01);
        chk("rd_cmd_ready_busy", cmd_ready, 0);
        bus.arready = 1;
        tick();
        bus.arready = 0;
        #1;
        chk("rd_rready", bus.rready, 1);
        chk("rd_arvalid_after_hs", bus.arvalid, 0);
        for (int i = 0; i < 4; i++) begin
            bus.rvalid = 1;
            bus.rdata  = rd_tab[i];
            bus.rlast  = (i == 3);
            bus.rresp  = 0;
            tick();
            chk("rd_valid_beat", rd_valid, 1);
            chk("rd_data_beat", rd_data, rd_tab[i]);
            if (i < 3) chk("rd_no_early_done", done, 0);
        end
        bus.rvalid = 0;
        bus.rlast  = 0;
        chk("rd_done", done, 1);
        chk("rd_err", err, 0);
        chk("rd_cmd_ready_with_done", cmd_ready, 0);
        tick();
        chk("rd_done_pulse_end", done, 0);
        chk("rd_valid_end", rd_valid, 0);
        chk("rd_idle_ready", cmd_ready, 1);

        // Write burst, 4 beats, one stall before beat 3
        start_cmd(1'b1, 5'h0a, 4'd3, 3'd1);
        #1;
        chk("wr_awvalid", bus.awvalid, 1);
        chk("wr_awaddr", bus.awaddr, 5'h0a);
        chk("wr_awlen", bus.awlen, 4'd3);
        chk("wr_awsize", bus.awsize, 3'd1);
        chk("wr_awburst", bus.awburst, 2'b01);
        chk("wr_arvalid_quiet", bus.arvalid, 0);
        bus.awready = 1;
        tick();
        bus.awready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus.wready = 0;
                #1;
                chk("wr_stall_wvalid", bus.wvalid, 1);
                chk("wr_stall_req", wr_req, 0);
                chk("wr_stall_wlast", bus.wlast, 0);
                tick();
            end
            wr_data    = wd_tab[i];
            bus.wready = 1;
            #1;
            chk("wr_wvalid", bus.wvalid, 1);
            chk("wr_req_beat", wr_req, 1);
            chk("wr_wdata", bus.wdata, wd_tab[i]);
            chk("wr_wlast", bus.wlast, (i == 3) ? 1 : 0);
            tick();
        end
        bus.wready = 0;
        #1;
        chk("wr_b_wvalid", bus.wvalid, 0);
        chk("wr_b_bready", bus.bready, 1);
        chk("wr_b_req", wr_req, 0);
        chk("wr_b_no_done", done, 0);
        bus.bvalid = 1;
        bus.bresp  = 0;
        tick();
        bus.bvalid = 0;
        chk("wr_done", done, 1);
        chk("wr_err", err, 0);
        chk("wr_cmd_ready_with_done", cmd_ready, 0);
        tick();
        chk("wr_done_pulse_end", done, 0);
        chk("wr_idle_ready", cmd_ready, 1);

        // Read len=3 with rlast on beat 2
        start_cmd(1'b0, 5'h03, 4'd3, 3'd0);
        bus.arready = 1;
        tick();
        bus.arready = 0;
        bus.rvalid = 1; bus.rdata = 16'h0001; bus.rlast = 0;
        tick();
        chk("early_beat1_valid", rd_valid, 1);
        chk("early_beat1_no_done", done, 0);
        bus.rdata = 16'h0002; bus.rlast = 1;
        tick();
        bus.rvalid = 0; bus.rlast = 0;
        chk("early_beat2_valid", rd_valid, 1);
        chk("early_beat2_data", rd_data, 16'h0002);
        chk("early_done", done, 1);
        chk("early_err", err, 1);
        chk("early_rready_off", bus.rready, 0);
        tick();
        chk("early_idle_ready", cmd_ready, 1);

        // Single-beat read without rlast: error
        start_cmd(1'b0, 5'h10, 4'd0, 3'd0);
        bus.arready = 1;
        tick();
        bus.arready = 0;
        bus.rvalid = 1; bus.rdata = 16'h5a5a; bus.rlast = 0; bus.rresp = 0;
        tick();
        bus.rvalid = 0;
        chk("len0_rd_data", rd_data, 16'h5a5a);
        chk("len0_rd_done", done, 1);
        chk("len0_rd_err_no_rlast", err, 1);
        tick();

        // Single-beat read with rlast but rresp error
        start_cmd(1'b0, 5'h11, 4'd0, 3'd0);
        bus.arready = 1;
        tick();
        bus.arready = 0;
        bus.rvalid = 1; bus.rlast = 1; bus.rresp = 1;
        tick();
        bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
        chk("len0_rresp_done", done, 1);
        chk("len0_rresp_err", err, 1);
        tick();

        // Single-beat write, wlast on first beat, bresp error
        start_cmd(1'b1, 5'h1f, 4'd0, 3'd1);
        bus.awready = 1;
        tick();
        bus.awready = 0;
        wr_data = 16'hc3c3;
        bus.wready = 1;
        #1;
        chk("len0_wr_wlast", bus.wlast, 1);
        chk("len0_wr_req", wr_req, 1);
        tick();
        bus.wready = 0;
        bus.bvalid = 1; bus.bresp = 1;
        tick();
        bus.bvalid = 0; bus.bresp = 0;
        chk("len0_wr_done", done, 1);
        chk("len0_wr_err_bresp", err, 1);
        tick();

        // arready never rises: timeout after 64 cycles
        start_cmd(1'b0, 5'h04, 4'd1, 3'd0);
        arv_cycles = 0;
        while (bus.arvalid === 1'b1 && arv_cycles < 200) begin
            arv_cycles++;
            tick();
        end
        chk("to_arvalid_cycles", arv_cycles, 64);
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_arvalid_low", bus.arvalid, 0);
        tick();
        chk("to_arvalid_stays_low", bus.arvalid, 0);
        chk("to_done_pulse_end", done, 0);
        chk("to_idle_ready", cmd_ready, 1);

        // Reset during the second W beat
        start_cmd(1'b1, 5'h08, 4'd3, 3'd1);
        bus.awready = 1;
        tick();
        bus.awready = 0;
        wr_data = 16'h0aaa;
        bus.wready = 1;
        tick();
        wr_data = 16'h0bbb;
        #1;
        chk("mid_rst_req_before", wr_req, 1);
        res = 1'b1;
        #1;
        chk("mid_rst_wvalid", bus.wvalid, 0);
        chk("mid_rst_wr_req", wr_req, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_done", done, 0);
        tick();
        chk("mid_rst_hold_done", done, 0);
        res = 1'b0;
        bus.wready = 0;
        #1;
        chk("mid_rst_rel_before_edge", cmd_ready, 0);
        tick();
        chk("mid_rst_rel_ready", cmd_ready, 1);
        chk("mid_rst_rel_no_done", done, 0);
        chk("mid_rst_rel_wvalid", bus.wvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
